// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DIV_W_DEFAULT = 4;

    // Quotient bit value replicated across the word on divide-by-zero.
    localparam logic DIV_DBZ_QUOT_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int div_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Ripple-borrow subtractor built from full-subtracter cells; computes minuend - subtrahend.
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] difference,
    output logic         borrow_out
);

    logic [W:0] borrow;

    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fs
            assign difference[gi] = minuend[gi] ^ subtrahend[gi] ^ borrow[gi];
            assign borrow[gi+1]   = (~minuend[gi] & subtrahend[gi])
                                  | (~(minuend[gi] ^ subtrahend[gi]) & borrow[gi]);
        end
    endgenerate

    assign borrow_out = borrow[W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional packed result port enabled by defining DIV_PACKED_RESULT_EN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
`ifdef DIV_PACKED_RESULT_EN
    ,
    output logic [2*N:0] result
`endif
);

    localparam int CW = div_cnt_w(N);
    localparam logic [N-1:0] DBZ_QUOT = {N{DIV_DBZ_QUOT_BIT}};

    div_state_e    state_q, state_d;
    logic [N-1:0]  q_work_q, q_work_d;
    logic [N:0]    r_work_q, r_work_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    r_shift, trial, r_next;
    logic [N-1:0]  q_next;
    logic          borrow;

    // The remainder MSB only guards the shift; it is always 0 at completion.
    logic unused_r_msb;
    assign unused_r_msb = r_work_q[N];

    assign r_shift = {r_work_q[N-1:0], q_work_q[N-1]};

    div_trial_sub #(.W(N + 1)) u_trial_sub (
        .minuend    (r_shift),
        .subtrahend ({1'b0, d_q}),
        .difference (trial),
        .borrow_out (borrow)
    );

    assign r_next = borrow ? r_shift : trial;
    assign q_next = {q_work_q[N-2:0], ~borrow};

    always_comb begin
        state_d     = state_q;
        q_work_d    = q_work_q;
        r_work_d    = r_work_q;
        d_d         = d_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            RUN: begin
                q_work_d = q_next;
                r_work_d = r_next;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    quotient_d  = q_next;
                    remainder_d = r_next[N-1:0];
                    dbz_d       = 1'b0;
                    state_d     = DONE;
                end
            end
            default: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_work_d = dividend;
                        r_work_d = '0;
                        d_d      = divisor;
                        count_d  = '0;
                        state_d  = RUN;
                    end else begin
                        quotient_d  = DBZ_QUOT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            q_work_q    <= '0;
            r_work_q    <= '0;
            d_q         <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_work_q    <= q_work_d;
            r_work_q    <= r_work_d;
            d_q         <= d_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

`ifdef DIV_PACKED_RESULT_EN
    logic [2*N:0] result_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q <= '0;
        end else begin
            result_q <= {dbz_d, remainder_d, quotient_d};
        end
    end

    assign result = result_q;
`endif

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
